elem_adder_arbiter: RTL and testbench
=====================================

Name: elem_adder_arbiter

Overview:
- Shares one modular element adder (fixed latency ADD_LAT, no stall, per-op modulus input) between NREQ vector-stream requesters.
- Grants whole bursts round-robin, from first beat to the beat with last set.
- Holds the adder's modulus stable while ops are in flight, draining the pipeline before a modulus change.
- Routes each result back to its owner using an ID tag pipeline aligned to the adder latency.

Parameters:
NREQ, 4, number of requesters (2..8)
ADD_LAT, 5, adder latency in cycles from add_in_valid to add_out_valid
ID, 0, instance identifier (informational only)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester beat valid
req_last  in  NREQ  final beat of the requester's burst
req_op1  in  NREQ*FSIZE  operand 1, requester i at [i*FSIZE +: FSIZE]
req_op2  in  NREQ*FSIZE  operand 2, same packing
req_p  in  NREQ*FSIZE  modulus; must be constant for the whole burst
req_ready  out  NREQ  beat accepted when req_valid[i] & req_ready[i]
add_in_valid  out  1  issue strobe to the adder
add_in_last  out  1  last flag to the adder
add_op1  out  FSIZE  operand 1 to the adder
add_op2  out  FSIZE  operand 2 to the adder
add_p  out  FSIZE  modulus to the adder, driven from p_reg
add_out_valid  in  1  result valid from the adder
add_out_last  in  1  result last flag from the adder
add_out  in  FSIZE  result data from the adder
rsp_valid  out  NREQ  one-hot result strobe
rsp_last  out  1  result last flag
rsp_data  out  FSIZE  result data on a shared bus
busy  out  1  high when state != IDLE or inflight != 0
err  out  1  sticky tag/valid mismatch (see Optional Feature)

Behaviour:
- Reset (async, rstn=0) clears all state:
  - state=IDLE, rr_ptr=0, grant_id=0, p_reg=0, inflight=0, tag pipe all invalid.
  - All outputs 0.
  - Reset mid-burst drops the burst; the adder shares rstn, so in-flight results are discarded and no rsp is emitted.
- FSM states are IDLE, DRAIN and BURST.
- IDLE: if any req_valid is set, pick the winner = first set bit at or after rr_ptr (cyclic) and register it in grant_id.
  - If req_p[winner] == p_reg, or inflight == 0: load p_reg and go to BURST.
  - Otherwise go to DRAIN.
  - If no req_valid is set, stay in IDLE.
- DRAIN: req_ready=0, no issue.
  - When inflight == 0: load p_reg <= req_p[grant_id] and go to BURST.
- BURST: req_ready[grant_id] = 1, all other bits 0.
  - add_in_valid = req_valid[grant_id] (combinational).
  - add_op1, add_op2 and add_in_last are muxed from grant_id.
  - On an accepted beat with req_last set: rr_ptr <= grant_id+1 (mod NREQ), then go to IDLE.
  - There is a 1-cycle bubble between bursts.
- Gaps in req_valid during a burst are allowed; the grant is held until last.
- add_p always equals p_reg and changes only when inflight == 0.
- inflight counter:
  - +1 on issue, -1 on add_out_valid; both in one cycle leaves it unchanged.
  - Range 0..ADD_LAT.
- Tag pipe: ADD_LAT-stage shift register of {valid, id}.
  - Stage 0 loads {add_in_valid, grant_id}.
  - The tail aligns with add_out_valid.
- Response path, registered 1 cycle:
  - rsp_valid <= add_out_valid ? onehot(tail.id) : 0.
  - rsp_last <= add_out_last.
  - rsp_data <= add_out.
- Latency from accepted beat to rsp_valid is ADD_LAT+1 cycles. Throughput is 1 beat/cycle within a burst.
- Results for a requester come out in issue order. Bursts from different requesters never interleave at the adder input.
- A requester dropping req_valid without ever asserting last holds the grant indefinitely. This is a requester protocol violation and is not recovered.

Optional Feature:
- Macro: ELEM_ADDER_ARB_TAG_CHECK_EN.
- Defined: err is set and held until reset when either:
  - add_out_valid != tail.valid, or
  - add_out_valid is set while inflight == 0.
- Not defined: err is tied to 0 and no check logic is built.

Test Plan:
- Single burst: req0 sends 4 beats, p=97, op1=90, op2=10 (each beat) -> rsp_valid=0001 on 4 consecutive cycles, rsp_data=3 each, rsp_last on the 4th; first rsp exactly ADD_LAT+1 = 6 cycles after the first accept.
- Round-robin: all 4 requesters valid with equal p=17, 2-beat bursts -> grant order 0,1,2,3; one idle cycle between bursts; no DRAIN entered; each rsp routed to its owner.
- Modulus change: req1 burst with p=17 immediately followed by req2 with p=23 -> DRAIN entered; req_ready[2] rises only after inflight reaches 0; add_p changes 17->23 only with inflight=0; req2 result (20+5) mod 23 = 2.
- Back-pressure gaps: req3 toggles valid every other cycle for 3 beats -> grant held throughout, no other requester serviced, 3 rsp in order.
- Reset mid-burst: assert rstn=0 with 3 beats in flight -> outputs 0 immediately; after release no stale rsp_valid and busy=0.
- With ELEM_ADDER_ARB_TAG_CHECK_EN: the bench forces a spurious add_out_valid while inflight=0 -> err=1 and stays 1 until reset.

Source files
------------

// File: rtl/elem_adder_arbiter.sv
// Round-robin burst arbiter that shares one fixed-latency modular adder between NREQ requesters.
// Optional tag/valid consistency check is built when ELEM_ADDER_ARB_TAG_CHECK_EN is defined.
module elem_adder_arbiter #(
   parameter int NREQ    = 4,
   parameter int ADD_LAT = 5,
   parameter int ID      = 0,
   parameter int FSIZE   = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_last,
   input  logic [NREQ*FSIZE-1:0] req_op1,
   input  logic [NREQ*FSIZE-1:0] req_op2,
   input  logic [NREQ*FSIZE-1:0] req_p,
   output logic [NREQ-1:0]       req_ready,
   output logic                  add_in_valid,
   output logic                  add_in_last,
   output logic [FSIZE-1:0]      add_op1,
   output logic [FSIZE-1:0]      add_op2,
   output logic [FSIZE-1:0]      add_p,
   input  logic                  add_out_valid,
   input  logic                  add_out_last,
   input  logic [FSIZE-1:0]      add_out,
   output logic [NREQ-1:0]       rsp_valid,
   output logic                  rsp_last,
   output logic [FSIZE-1:0]      rsp_data,
   output logic                  busy,
   output logic                  err
);

   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int IDW1 = IDW + 1;
   localparam int CW   = $clog2(ADD_LAT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_BURST = 2'd2;

   // Packed views share the flat bus layout: requester g sits at [g*FSIZE +: FSIZE].
   logic [NREQ-1:0][FSIZE-1:0] op1_a, op2_a, p_a;
   assign op1_a = req_op1;
   assign op2_a = req_op2;
   assign p_a   = req_p;

   logic [1:0]       state_q, state_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [FSIZE-1:0] p_q, p_d;
   logic [CW-1:0]    inflight_q, inflight_d;

   logic [ADD_LAT-1:0]            vld_pipe_q;
   logic [ADD_LAT-1:0][IDW-1:0]   tag_id_q;

   logic [NREQ-1:0]  rsp_valid_q;
   logic             rsp_last_q;
   logic [FSIZE-1:0] rsp_data_q;

   // Cyclic priority search starting at rr_q.
   logic           win_found;
   logic [IDW-1:0] win_id;
   logic [IDW:0]   sum;
   always_comb begin
      win_found = 1'b0;
      win_id    = rr_q;
      sum       = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_q} + IDW1'(k);
         if (sum >= IDW1'(NREQ)) sum = sum - IDW1'(NREQ);
         if (!win_found && req_valid[sum[IDW-1:0]]) begin
            win_found = 1'b1;
            win_id    = sum[IDW-1:0];
         end
      end
   end

   logic in_burst, beat_acc, dec;
   assign in_burst = (state_q == S_BURST);
   assign beat_acc = in_burst & req_valid[grant_q];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      p_d     = p_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               grant_d = win_id;
               if ((p_a[win_id] == p_q) || (inflight_q == '0)) begin
                  p_d     = p_a[win_id];
                  state_d = S_BURST;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (inflight_q == '0) begin
               p_d     = p_a[grant_q];
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            if (beat_acc && req_last[grant_q]) begin
               rr_d    = (grant_q == IDW'(NREQ-1)) ? '0 : grant_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (in_burst) req_ready[grant_q] = 1'b1;
   end

   assign add_in_valid = beat_acc;
   assign add_in_last  = in_burst & req_last[grant_q];
   assign add_op1      = in_burst ? op1_a[grant_q] : '0;
   assign add_op2      = in_burst ? op2_a[grant_q] : '0;
   assign add_p        = p_q;

   // A result with nothing outstanding is spurious; it must not wrap the counter.
   assign dec = add_out_valid & (inflight_q != '0);
   always_comb begin
      inflight_d = inflight_q;
      case ({add_in_valid, dec})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         rr_q       <= '0;
         p_q        <= '0;
         inflight_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_q       <= rr_d;
         p_q        <= p_d;
         inflight_q <= inflight_d;
      end
   end

   // Tag pipe: the tail lines up with add_out_valid for the same op.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_pipe_q <= '0;
         tag_id_q   <= '0;
      end else begin
         for (int k = ADD_LAT-1; k > 0; k--) begin
            vld_pipe_q[k] <= vld_pipe_q[k-1];
            tag_id_q[k]   <= tag_id_q[k-1];
         end
         vld_pipe_q[0] <= add_in_valid;
         tag_id_q[0]   <= grant_q;
      end
   end

   logic [NREQ-1:0] tail_oh;
   always_comb begin
      tail_oh = '0;
      tail_oh[tag_id_q[ADD_LAT-1]] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid_q <= '0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= add_out_valid ? tail_oh : '0;
         rsp_last_q  <= add_out_last;
         rsp_data_q  <= add_out;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_last  = rsp_last_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q != S_IDLE) | (inflight_q != '0);

   logic [31:0] unused_id;
   assign unused_id = 32'(ID);

`ifdef ELEM_ADDER_ARB_TAG_CHECK_EN
   logic err_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q <= 1'b0;
      end else if ((add_out_valid != vld_pipe_q[ADD_LAT-1]) ||
                   (add_out_valid && (inflight_q == '0))) begin
         err_q <= 1'b1;
      end
   end
   assign err = err_q;
`else
   logic unused_tail;
   assign unused_tail = vld_pipe_q[ADD_LAT-1];
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_elem_adder_arbiter.sv
// Randomized + directed bench for elem_adder_arbiter with a behavioural adder and per-requester scoreboard.
module tb_elem_adder_arbiter;
   localparam int NREQ    = 4;
   localparam int ADD_LAT = 5;
   localparam int FSIZE   = 16;

   logic                  clk = 1'b0;
   logic                  rstn = 1'b0;
   logic [NREQ-1:0]       req_valid = '0, req_last = '0;
   logic [NREQ*FSIZE-1:0] req_op1 = '0, req_op2 = '0, req_p = '0;
   logic [NREQ-1:0]       req_ready;
   logic                  add_in_valid, add_in_last;
   logic [FSIZE-1:0]      add_op1, add_op2, add_p;
   logic                  add_out_valid, add_out_last;
   logic [FSIZE-1:0]      add_out;
   logic [NREQ-1:0]       rsp_valid;
   logic                  rsp_last;
   logic [FSIZE-1:0]      rsp_data;
   logic                  busy, err;

   elem_adder_arbiter #(.NREQ(NREQ), .ADD_LAT(ADD_LAT), .ID(0), .FSIZE(FSIZE)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_last(req_last),
      .req_op1(req_op1), .req_op2(req_op2), .req_p(req_p), .req_ready(req_ready),
      .add_in_valid(add_in_valid), .add_in_last(add_in_last),
      .add_op1(add_op1), .add_op2(add_op2), .add_p(add_p),
      .add_out_valid(add_out_valid), .add_out_last(add_out_last), .add_out(add_out),
      .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_data(rsp_data),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Behavioural adder: fixed latency, shares rstn with the arbiter.
   logic [ADD_LAT-1:0] av;
   logic               al [ADD_LAT];
   logic [FSIZE-1:0]   ad [ADD_LAT];
   logic               spur = 1'b0;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         av <= '0;
         for (int k = 0; k < ADD_LAT; k++) begin al[k] <= 1'b0; ad[k] <= '0; end
      end else begin
         for (int k = ADD_LAT-1; k > 0; k--) begin
            av[k] <= av[k-1]; al[k] <= al[k-1]; ad[k] <= ad[k-1];
         end
         av[0] <= add_in_valid;
         al[0] <= add_in_valid & add_in_last;
         ad[0] <= (add_in_valid && add_p != 0) ?
                  FSIZE'((int'(add_op1) + int'(add_op2)) % int'(add_p)) : '0;
      end
   end
   assign add_out_valid = av[ADD_LAT-1] | spur;
   assign add_out_last  = al[ADD_LAT-1];
   assign add_out       = ad[ADD_LAT-1];

   typedef struct { int op1; int op2; int p; bit last; int gap; } beat_t;
   typedef struct { int data; bit last; int cyc; } exp_t;

   beat_t bq [NREQ][$];
   exp_t  sb [NREQ][$];
   int    starts[$];
   int    bgaps[$];
   int    rcnt [NREQ];
   int    last_data [NREQ];
   int    n_chk = 0, n_pass = 0;
   int    cyc = 0, n_acc = 0, open_owner = -1, last_end = 0, prev_p = 0;
   bit    ign_rsp = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic push_beat(input int r, input int op1, input int op2, input int p,
                            input bit last, input int gap);
      beat_t b;
      b.op1 = op1; b.op2 = op2; b.p = p; b.last = last; b.gap = gap;
      bq[r].push_back(b);
   endtask

   function automatic bit all_done();
      for (int i = 0; i < NREQ; i++)
         if (bq[i].size() != 0 || sb[i].size() != 0) return 1'b0;
      return open_owner < 0;
   endfunction

   task automatic flush();
      for (int i = 0; i < NREQ; i++) begin
         bq[i].delete(); sb[i].delete(); rcnt[i] = 0; last_data[i] = -1;
      end
      starts.delete(); bgaps.delete();
      open_owner = -1; prev_p = 0; spur = 1'b0; n_acc = 0;
      req_valid = '0; req_last = '0; req_op1 = '0; req_op2 = '0; req_p = '0;
   endtask

   task automatic step();
      beat_t b;
      exp_t  e;
      int    r;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = 1'b0;
         req_last[i]  = 1'b0;
         if (bq[i].size() != 0) begin
            b = bq[i][0];
            if (b.gap > 0) begin
               b.gap--;
               bq[i][0] = b;
            end else begin
               req_valid[i] = 1'b1;
               req_last[i]  = b.last;
               req_op1[i*FSIZE +: FSIZE] = FSIZE'(b.op1);
               req_op2[i*FSIZE +: FSIZE] = FSIZE'(b.op2);
               req_p[i*FSIZE +: FSIZE]   = FSIZE'(b.p);
            end
         end
      end
      #1;
      if (int'(add_p) != prev_p) begin
         chk("p_change_with_ops_in_adder", $countones(av), 0);
         prev_p = int'(add_p);
      end
      if (req_ready != '0) chk("ready_onehot", $countones(req_ready), 1);
      if (rsp_valid != '0 && !ign_rsp) begin
         chk("rsp_onehot", $countones(rsp_valid), 1);
         r = 0;
         for (int i = NREQ-1; i >= 0; i--) if (rsp_valid[i]) r = i;
         if (sb[r].size() == 0) begin
            chk("rsp_unexpected", int'(rsp_valid), 0);
         end else begin
            e = sb[r].pop_front();
            chk("rsp_data", int'(rsp_data), e.data);
            chk("rsp_last", int'(rsp_last), int'(e.last));
            chk("rsp_latency", cyc - e.cyc, ADD_LAT + 1);
            rcnt[r]++;
            last_data[r] = int'(rsp_data);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            b = bq[i].pop_front();
            n_acc++;
            if (open_owner >= 0) chk("burst_owner", i, open_owner);
            else begin
               starts.push_back(i);
               bgaps.push_back(cyc - last_end);
               open_owner = i;
            end
            e.data = (b.op1 + b.op2) % b.p;
            e.last = b.last;
            e.cyc  = cyc;
            sb[i].push_back(e);
            if (b.last) begin open_owner = -1; last_end = cyc; end
         end
      end
   endtask

   task automatic run_until_idle(input int budget);
      int n = 0;
      while (!all_done() && n < budget) begin step(); n++; end
      chk("completion_within_budget", int'(all_done()), 1);
      step();
      chk("busy_after_drain", int'(busy), 0);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rstn = 1'b0;
      flush();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
      chk({tag, "_rsp_last"}, int'(rsp_last), 0);
      chk({tag, "_rsp_data"}, int'(rsp_data), 0);
      chk({tag, "_req_ready"}, int'(req_ready), 0);
      chk({tag, "_add_in_valid"}, int'(add_in_valid), 0);
      chk({tag, "_add_p"}, int'(add_p), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_err"}, int'(err), 0);
   endtask

   initial begin
      int p, len, r, n;
      flush();
      #1;
      chk_outputs_zero("reset");
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // Single burst, req0: (90+10) mod 97 = 3 on four beats.
      for (int k = 0; k < 4; k++) push_beat(0, 90, 10, 97, k == 3, 0);
      run_until_idle(100);
      chk("single_rsp_count", rcnt[0], 4);
      chk("single_rsp_data", last_data[0], 3);

      // Round-robin with a shared modulus: order 0..3, one-cycle bubble, no drain.
      reset_dut();
      for (int i = 0; i < NREQ; i++)
         for (int k = 0; k < 2; k++)
            push_beat(i, int'($urandom_range(16)), int'($urandom_range(16)), 17, k == 1, 0);
      run_until_idle(200);
      chk("rr_burst_count", starts.size(), NREQ);
      for (int k = 0; k < NREQ && k < starts.size(); k++) begin
         chk("rr_order", starts[k], k);
         chk("rr_rsp_count", rcnt[k], 2);
         if (k > 0) chk("rr_bubble", bgaps[k], 2);
      end

      // Modulus change forces a drain before req2 is granted.
      reset_dut();
      push_beat(1, 3, 4, 17, 1'b0, 0);
      push_beat(1, 5, 6, 17, 1'b1, 0);
      push_beat(2, 20, 5, 23, 1'b1, 0);
      run_until_idle(200);
      chk("mod_burst_count", starts.size(), 2);
      if (starts.size() == 2) begin
         chk("mod_order_first", starts[0], 1);
         chk("mod_order_second", starts[1], 2);
         chk("mod_drain_gap_gt_bubble", int'(bgaps[1] > 2), 1);
      end
      chk("mod_req2_data", last_data[2], 2);
      chk("mod_add_p_final", int'(add_p), 23);

      // Gapped burst from req3 holds the grant while req0 waits.
      reset_dut();
      push_beat(3, 1, 0, 31, 1'b0, 0);
      push_beat(3, 2, 0, 31, 1'b0, 1);
      push_beat(3, 3, 0, 31, 1'b1, 1);
      n = 0;
      while (open_owner != 3 && n < 10) begin step(); n++; end
      chk("bp_req3_granted", open_owner, 3);
      push_beat(0, 7, 8, 31, 1'b0, 0);
      push_beat(0, 9, 1, 31, 1'b1, 0);
      run_until_idle(200);
      chk("bp_burst_count", starts.size(), 2);
      if (starts.size() == 2) begin
         chk("bp_order_first", starts[0], 3);
         chk("bp_order_second", starts[1], 0);
      end
      chk("bp_req3_rsp_count", rcnt[3], 3);
      chk("bp_req3_last_data", last_data[3], 3);

      // Reset with three beats in flight: outputs clear, no stale response afterwards.
      reset_dut();
      for (int k = 0; k < 6; k++) push_beat(0, k, 1, 97, k == 5, 0);
      n = 0;
      while (n_acc < 3 && n < 20) begin step(); n++; end
      chk("midrst_three_accepted", n_acc, 3);
      rstn = 1'b0;
      #1;
      chk_outputs_zero("midrst");
      flush();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 12; k++) step();
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_no_rsp", rcnt[0], 0);

      // Random bursts; moduli from a small set so both drain and no-drain paths occur.
      reset_dut();
      for (int b = 0; b < 40; b++) begin
         r   = int'($urandom_range(NREQ-1));
         len = int'($urandom_range(5, 1));
         case ($urandom_range(3))
            0: p = 13;
            1: p = 61;
            2: p = 97;
            default: p = 199;
         endcase
         for (int k = 0; k < len; k++)
            push_beat(r, int'($urandom_range(p-1)), int'($urandom_range(p-1)), p, k == len-1,
                      ($urandom_range(3) == 0) ? 1 : 0);
      end
      run_until_idle(8000);
      chk("rand_err_quiet", int'(err), 0);

`ifdef ELEM_ADDER_ARB_TAG_CHECK_EN
      // Spurious adder result with nothing in flight sets the sticky error.
      reset_dut();
      ign_rsp = 1'b1;
      @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      #1;
      chk("err_set", int'(err), 1);
      for (int k = 0; k < 5; k++) step();
      chk("err_sticky", int'(err), 1);
      reset_dut();
      ign_rsp = 1'b0;
      #1;
      chk("err_cleared_by_reset", int'(err), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
